// File: rtl/yannickreiss_result_display_pkg.sv
// Shared definitions for the result display: segment codes, FSM states and
// the double-dabble step helper.
package yannickreiss_result_display_pkg;

    localparam int WORD_W = 6;
    localparam int N_ITER = 6;

    // Bit 6 is segment a, bit 0 is segment g.
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/yannickreiss_result_display_if.sv
// 8-pin tile bus: io_in carries clock, reset and the result word; io_out
// carries the segments and the digit select.
interface yannickreiss_result_display_if;
    logic [7:0] io_in;
    logic [7:0] io_out;

    modport master (output io_in, input io_out);
    modport slave  (input io_in, output io_out);
endinterface

// File: rtl/yannickreiss_seg7_enc.sv
// BCD digit to active-high 7-segment code (bit 6 = a), with a blank override.
module yannickreiss_seg7_enc
    import yannickreiss_result_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/yannickreiss_result_display.sv
// Debounced result-word capture, binary to two-digit conversion and a
// multiplexed 7-segment scan. Define SPLIT_MODE_EN to show two octal fields.
module yannickreiss_result_display
    import yannickreiss_result_display_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int SCAN_DIV_W    = 10
)
(
    yannickreiss_result_display_if.slave tile
);

    localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

    logic clk;
    logic srst;
    logic [WORD_W-1:0] word;

    assign clk  = tile.io_in[0];
    assign srst = tile.io_in[1];

    // io_in[2] is the word MSB.
    generate
        for (genvar gi = 0; gi < WORD_W; gi++) begin : g_word
            assign word[WORD_W-1-gi] = tile.io_in[2+gi];
        end
    endgenerate

    logic [WORD_W-1:0]     s1_reg, s2_reg, cand_reg;
    logic [3:0]            cnt_reg;
    logic [WORD_W-1:0]     shown_reg, conv_reg;
    logic [3:0]            bcd_t_reg, bcd_u_reg;
    logic [3:0]            tens_reg, units_reg;
    logic [SCAN_DIV_W-1:0] scan_reg;
    logic [6:0]            seg_reg;
    logic                  sel_reg;
    state_t                state_reg;
    logic                  accept;

`ifndef SPLIT_MODE_EN
    logic [WORD_W-1:0]     bin_reg;
    logic [2:0]            iter_reg;
    logic [13:0]           dd_next;

    // One double-dabble step: correct both nibbles, then shift the whole chain.
    always_comb begin
        dd_next = {add3(bcd_t_reg), add3(bcd_u_reg), bin_reg} << 1;
    end
`endif

    // Debounce and scan counter.
    always_ff @(posedge clk) begin
        if (srst) begin
            s1_reg   <= '0;
            s2_reg   <= '0;
            cand_reg <= '0;
            cnt_reg  <= '0;
            scan_reg <= '0;
        end else begin
            s1_reg   <= word;
            s2_reg   <= s1_reg;
            scan_reg <= scan_reg + {{(SCAN_DIV_W-1){1'b0}}, 1'b1};
            if (s2_reg != cand_reg) begin
                cand_reg <= s2_reg;
                cnt_reg  <= '0;
            end else if (cnt_reg != STABLE_N) begin
                cnt_reg <= cnt_reg + 4'd1;
            end
        end
    end

    assign accept = (cnt_reg == STABLE_N) && (cand_reg != shown_reg) && (state_reg == ST_IDLE);

    // conv_reg holds the word being converted so a newer candidate that
    // arrives mid-conversion still differs from shown_reg after commit.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= ST_IDLE;
            conv_reg  <= '0;
            shown_reg <= '0;
            bcd_t_reg <= '0;
            bcd_u_reg <= '0;
            tens_reg  <= '0;
            units_reg <= '0;
`ifndef SPLIT_MODE_EN
            bin_reg   <= '0;
            iter_reg  <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        conv_reg <= cand_reg;
`ifdef SPLIT_MODE_EN
                        bcd_t_reg <= {1'b0, cand_reg[5:3]};
                        bcd_u_reg <= {1'b0, cand_reg[2:0]};
                        state_reg <= ST_COMMIT;
`else
                        bin_reg   <= cand_reg;
                        bcd_t_reg <= '0;
                        bcd_u_reg <= '0;
                        iter_reg  <= '0;
                        state_reg <= ST_SHIFT;
`endif
                    end
                end
                ST_SHIFT: begin
`ifdef SPLIT_MODE_EN
                    state_reg <= ST_IDLE;
`else
                    bcd_t_reg <= dd_next[13:10];
                    bcd_u_reg <= dd_next[9:6];
                    bin_reg   <= dd_next[5:0];
                    iter_reg  <= iter_reg + 3'd1;
                    if (iter_reg == 3'(N_ITER - 1)) begin
                        state_reg <= ST_COMMIT;
                    end
`endif
                end
                ST_COMMIT: begin
                    tens_reg  <= bcd_t_reg;
                    units_reg <= bcd_u_reg;
                    shown_reg <= conv_reg;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    logic       scan_msb;
    logic [3:0] digit_mux;
    logic       blank;
    logic [6:0] seg_w;

    assign scan_msb  = scan_reg[SCAN_DIV_W-1];
    assign digit_mux = scan_msb ? units_reg : tens_reg;
`ifdef SPLIT_MODE_EN
    assign blank = 1'b0;
`else
    assign blank = !scan_msb && (tens_reg == 4'd0);
`endif

    yannickreiss_seg7_enc u_enc (
        .digit (digit_mux),
        .blank (blank),
        .seg   (seg_w)
    );

    // Segments and select are registered together so they never disagree.
    always_ff @(posedge clk) begin
        if (srst) begin
            seg_reg <= '0;
            sel_reg <= 1'b0;
        end else begin
            seg_reg <= seg_w;
            sel_reg <= scan_msb;
        end
    end

    logic [7:0] io_out_w;

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_seg
            assign io_out_w[gi] = seg_reg[6-gi];
        end
    endgenerate

    assign io_out_w[7] = sel_reg;
    assign tile.io_out = io_out_w;

endmodule

// File: tb/tb_yannickreiss_result_display.sv
// Directed bench for yannickreiss_result_display; short scan period so both
// digit phases are visited quickly.
module tb_yannickreiss_result_display;

    localparam int SW = 3;

    localparam logic [6:0] C0 = 7'b1111110;
    localparam logic [6:0] C1 = 7'b0110000;
    localparam logic [6:0] C2 = 7'b1101101;
    localparam logic [6:0] C3 = 7'b1111001;
    localparam logic [6:0] C4 = 7'b0110011;
    localparam logic [6:0] C5 = 7'b1011011;
    localparam logic [6:0] C6 = 7'b1011111;
    localparam logic [6:0] C7 = 7'b1110000;
    localparam logic [6:0] C9 = 7'b1111011;
    localparam logic [6:0] CB = 7'b0000000;

`ifdef SPLIT_MODE_EN
    localparam logic [6:0] E0_T  = C0, E0_U  = C0;
    localparam logic [6:0] E49_T = C6, E49_U = C1;
    localparam logic [6:0] B63_T = C7, B63_U = C7;
    localparam logic [6:0] E7_T  = C0, E7_U  = C7;
    localparam logic [6:0] E12_T = C1, E12_U = C4;
    localparam logic [6:0] E35_T = C4, E35_U = C3;
    localparam logic [6:0] E19_T = C2, E19_U = C3;
    localparam logic [6:0] E5_T  = C0, E5_U  = C5;
    localparam int LAT_MIN = 7,  LAT_MAX = 16;
`else
    localparam logic [6:0] E0_T  = CB, E0_U  = C0;
    localparam logic [6:0] E49_T = C4, E49_U = C9;
    localparam logic [6:0] B63_T = C6, B63_U = C3;
    localparam logic [6:0] E7_T  = CB, E7_U  = C7;
    localparam logic [6:0] E12_T = C1, E12_U = C2;
    localparam logic [6:0] E35_T = C3, E35_U = C5;
    localparam logic [6:0] E19_T = C1, E19_U = C9;
    localparam logic [6:0] E5_T  = CB, E5_U  = C5;
    localparam int LAT_MIN = 13, LAT_MAX = 24;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] word;
    int checks = 0;
    int errors = 0;

    yannickreiss_result_display_if tile ();

    assign tile.io_in = {word[0], word[1], word[2], word[3], word[4], word[5], rst, clk};

    yannickreiss_result_display #(.STABLE_CYCLES(4), .SCAN_DIV_W(SW)) dut (
        .tile (tile)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [7:0] o);
        return {o[0], o[1], o[2], o[3], o[4], o[5], o[6]};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
        $display("check %s: observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic check_phase(input logic sel, input logic [6:0] exp, input string tag);
        logic [6:0] obs;
        bit found;
        found = 0;
        obs = 'x;
        for (int i = 0; i < 16 && !found; i++) begin
            if (tile.io_out[7] === sel) begin
                obs = seg_of(tile.io_out);
                found = 1;
            end else begin
                @(negedge clk);
            end
        end
        chk(tag, {1'b0, obs}, {1'b0, exp});
    endtask

    initial begin
        logic [6:0] code;
        logic       sel0;
        int         n;
        int         first;
        int         bad;
        logic [6:0] tseq [8];
        logic [6:0] useq [8];
        int         tn, un;

        for (int i = 0; i < 8; i++) begin
            tseq[i] = '0;
            useq[i] = '0;
        end

        // Reset held two cycles.
        rst = 1'b1;
        word = 6'd0;
        @(negedge clk);
        chk("reset_cyc1", tile.io_out, 8'h00);
        @(negedge clk);
        chk("reset_cyc2", tile.io_out, 8'h00);
        rst = 1'b0;
        check_phase(1'b0, E0_T, "post_reset_tens");
        check_phase(1'b1, E0_U, "post_reset_units");

        // 63 for three cycles, then 49: 63 must never reach the display.
        word = 6'd63;
        repeat (3) @(negedge clk);
        word = 6'd49;
        first = -1;
        bad = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            code = seg_of(tile.io_out);
            if (tile.io_out[7] === 1'b0 && code === B63_T && B63_T !== E0_T) bad++;
            if (tile.io_out[7] === 1'b1 && code === B63_U) bad++;
            if (first < 0 && tile.io_out[7] === 1'b1 && code === E49_U) first = i;
        end
        chk("glitch_63_never_shown", 8'(bad), 8'd0);
        chk("lat49_not_early", 8'(first >= LAT_MIN), 8'd1);
        chk("lat49_not_late", 8'(first >= 0 && first <= LAT_MAX), 8'd1);
        check_phase(1'b0, E49_T, "w49_tens");
        check_phase(1'b1, E49_U, "w49_units");

        // Digit select toggles every 2^(SW-1) cycles.
        sel0 = tile.io_out[7];
        n = 0;
        while (tile.io_out[7] === sel0 && n < 20) begin @(negedge clk); n++; end
        sel0 = tile.io_out[7];
        n = 0;
        while (tile.io_out[7] === sel0 && n < 20) begin @(negedge clk); n++; end
        chk("scan_half_period", 8'(n), 8'(1 << (SW - 1)));

        // Reset in the middle of a conversion.
        word = 6'd63;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        word = 6'd0;
        @(negedge clk);
        chk("reset_mid_shift", tile.io_out, 8'h00);
        rst = 1'b0;
        check_phase(1'b0, E0_T, "abort_tens");
        check_phase(1'b1, E0_U, "abort_units");
        word = 6'd7;
        repeat (22) @(negedge clk);
        check_phase(1'b0, E7_T, "w7_tens");
        check_phase(1'b1, E7_U, "w7_units");

        // 12, then 35 while 12 is converting: both commit in order, nothing else shown.
        word = 6'd12;
        repeat (10) @(negedge clk);
        word = 6'd35;
        tn = 0;
        un = 0;
        for (int i = 0; i < 40; i++) begin
            code = seg_of(tile.io_out);
            if (tile.io_out[7] === 1'b0) begin
                if ((tn == 0 || tseq[tn-1] !== code) && tn < 8) begin tseq[tn] = code; tn++; end
            end else begin
                if ((un == 0 || useq[un-1] !== code) && un < 8) begin useq[un] = code; un++; end
            end
            @(negedge clk);
        end
        chk("seq_tens_count", 8'(tn), 8'd3);
        chk("seq_tens_0", {1'b0, tseq[0]}, {1'b0, E7_T});
        chk("seq_tens_1", {1'b0, tseq[1]}, {1'b0, E12_T});
        chk("seq_tens_2", {1'b0, tseq[2]}, {1'b0, E35_T});
        chk("seq_units_count", 8'(un), 8'd3);
        chk("seq_units_0", {1'b0, useq[0]}, {1'b0, E7_U});
        chk("seq_units_1", {1'b0, useq[1]}, {1'b0, E12_U});
        chk("seq_units_2", {1'b0, useq[2]}, {1'b0, E35_U});

        // Octal-field vectors (decimal interpretation in the default build).
        word = 6'b010_011;
        repeat (22) @(negedge clk);
        check_phase(1'b0, E19_T, "w19_tens");
        check_phase(1'b1, E19_U, "w19_units");
        word = 6'b000_101;
        repeat (22) @(negedge clk);
        check_phase(1'b0, E5_T, "w5_tens");
        check_phase(1'b1, E5_U, "w5_units");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
